pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard and stall sequencer for the 5-stage pipeline. Drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM/MEM/WB registers. Resolves load-use stalls, taken-branch and jump flushes, and multi-cycle data-memory freezes. Keeps saturating stall and flush event counters for performance monitoring.

## Interface
- MEM_LAT, 3, data-memory access latency in cycles, ≥1
- CNT_W, 32, width of the performance counters
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- if_id_rs_i  in  5  rs field of the instruction in IF/ID
- if_id_rt_i  in  5  rt field of the instruction in IF/ID
- id_ex_rt_i  in  5  rt (load destination) of the instruction in ID/EX
- id_ex_memtoreg_i  in  1  ID/EX instruction is a load
- id_ex_regwrite_i  in  1  ID/EX instruction writes a register
- jump_i  in  1  jump decoded in ID
- branch_taken_i  in  1  branch resolved taken in EX (IsBranch & zero)
- mem_access_i  in  1  EX/MEM instruction performs a load or store
- cnt_clr_i  in  1  synchronous clear of both counters
- pc_write_o  out  1  PC load enable
- if_id_write_o  out  1  IF/ID load enable
- if_id_flush_o  out  1  IF/ID loads NOP
- id_ex_write_o  out  1  ID/EX load enable
- id_ex_flush_o  out  1  ID/EX loads bubble (all control fields 0)
- back_write_o  out  1  EX/MEM and MEM/WB load enable
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0
- flush_cnt_o  out  CNT_W  cycles with if_id_flush_o=1

## Operation
- FSM states: RUN, MEM_WAIT, MEM_RELEASE. Reset state is RUN, lat_cnt=0, both counters 0.
- load_use = id_ex_memtoreg_i & id_ex_regwrite_i & (id_ex_rt_i≠0) & (id_ex_rt_i==if_id_rs_i | id_ex_rt_i==if_id_rt_i).
- freeze = (state==MEM_WAIT) | (state==RUN & mem_access_i & MEM_LAT>1).
- Priority, highest first: freeze > branch_taken_i > load_use > jump_i > normal.
- freeze: all write enables 0, all flushes 0. Branch, load-use and jump are masked.
- branch_taken_i: all writes 1, if_id_flush_o=1, id_ex_flush_o=1.
- load_use: pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1, id_ex_write_o=1, back_write_o=1.
- jump_i: all writes 1, if_id_flush_o=1.
- normal: all writes 1, flushes 0.
- RUN with mem_access_i & MEM_LAT>1:
  - MEM_LAT==2 → next state MEM_RELEASE.
  - otherwise lat_cnt←MEM_LAT-3 and next state MEM_WAIT.
- MEM_WAIT: lat_cnt==0 → MEM_RELEASE; otherwise lat_cnt decrements.
- MEM_RELEASE: decodes like RUN but ignores mem_access_i, which prevents a retrigger by the same instruction. Next state is always RUN.
- Total freeze per access is exactly MEM_LAT-1 cycles. MEM_LAT==1 never freezes and the FSM stays in RUN.
- Counters saturate at all-ones.
  - cnt_clr_i has priority over increment and zeroes the counter that cycle.
  - stall_cnt_o counts both freeze and load-use cycles.

## Timing
- All outputs except the counters are combinational from state and the current inputs; no input-to-effect latency.
- Counters and state update on rising clk_i. Counter values appear one cycle after the counted cycle.
- rst_n_i low asynchronously forces state=RUN, lat_cnt=0 and counters=0, regardless of mid-freeze.
  - With quiet inputs, outputs are then: all writes 1, flushes 0.
- A branch held in a frozen EX stage takes effect in the MEM_RELEASE cycle.
- Simultaneous branch_taken_i and load_use: flush only, no stall. The stalled instruction is on the wrong path.
- Back-to-back memory accesses:
  - The second access reaches EX/MEM in the RUN cycle after MEM_RELEASE.
  - It freezes again, with no idle freeze-free gap beyond the MEM_RELEASE cycle.

## Structure
- The shared pipeline package holds the state enum (RUN, MEM_WAIT, MEM_RELEASE) and the REG_ZERO=5'd0 constant.
- One sub-module, sat_counter (CNT_W, inc, clr), is instantiated twice.
- The FSM and hazard decode live in this block.

## Test plan
- Load-use: id_ex_memtoreg_i=1, regwrite=1, id_ex_rt_i=5, if_id_rs_i=5 → pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1 for 1 cycle; stall_cnt_o=1 next cycle. Repeat with id_ex_rt_i=0 → no stall.
- Taken branch with a coincident load-use hazard → if_id_flush_o=1, id_ex_flush_o=1, pc_write_o=1; flush_cnt_o increments by 1, stall_cnt_o unchanged.
- MEM_LAT=3, mem_access_i held high for 3 cycles → back_write_o=0 for exactly 2 cycles, then 1 in MEM_RELEASE; stall_cnt_o=2.
- Branch_taken_i asserted during a freeze → no flush while frozen; flushes assert in the MEM_RELEASE cycle.
- rst_n_i pulsed low in MEM_WAIT → outputs immediately return to all writes 1; counters read 0; no freeze after release with mem_access_i=0.
- Preload stall_cnt to all-ones (CNT_W=4 build) plus a load-use stall → counter holds 4'hF; cnt_clr_i=1 → 0 next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard sequencer: the sequencer state
// encoding and the architectural zero register.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MEM_WAIT    = 2'd1,
        MEM_RELEASE = 2'd2
    } hazardStateT;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Count qualifying cycles, holding at all-ones once full.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline. Decodes load-use
// stalls, branch/jump flushes and multi-cycle data-memory freezes into the
// pipeline register enables, and keeps stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       if_id_rs_i,
    input  logic [4:0]       if_id_rt_i,
    input  logic [4:0]       id_ex_rt_i,
    input  logic             id_ex_memtoreg_i,
    input  logic             id_ex_regwrite_i,
    input  logic             jump_i,
    input  logic             branch_taken_i,
    input  logic             mem_access_i,
    input  logic             cnt_clr_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_write_o,
    output logic             id_ex_flush_o,
    output logic             back_write_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // A single-cycle memory never freezes; longer ones freeze MEM_LAT-1
    // cycles: the RUN trigger cycle plus MEM_LAT-2 cycles counted in MEM_WAIT.
    localparam bit MULTI_CYCLE = (MEM_LAT > 1);
    localparam int LAT_W = (MEM_LAT > 3) ? $clog2(MEM_LAT - 2) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((MEM_LAT >= 3) ? (MEM_LAT - 3) : 0);

    hazardStateT      state;
    hazardStateT      nextState;
    logic [LAT_W-1:0] latCnt;
    logic [LAT_W-1:0] nextLatCnt;
    logic             loadUse;
    logic             freeze;

    assign loadUse = id_ex_memtoreg_i && id_ex_regwrite_i && (id_ex_rt_i != REG_ZERO) &&
                     ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

    // MEM_RELEASE deliberately ignores mem_access_i so the instruction that
    // just finished its access cannot retrigger a freeze.
    assign freeze = (state == MEM_WAIT) || ((state == RUN) && mem_access_i && MULTI_CYCLE);

    // State and latency counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= RUN;
            latCnt <= '0;
        end else begin
            state  <= nextState;
            latCnt <= nextLatCnt;
        end
    end

    // Next-state logic for the memory freeze sequence.
    always_comb begin
        nextState  = state;
        nextLatCnt = latCnt;
        case (state)
            RUN: begin
                if (mem_access_i && MULTI_CYCLE) begin
                    if (MEM_LAT == 2) begin
                        nextState = MEM_RELEASE;
                    end else begin
                        nextState  = MEM_WAIT;
                        nextLatCnt = LAT_LOAD;
                    end
                end
            end
            MEM_WAIT: begin
                if (latCnt == '0) begin
                    nextState = MEM_RELEASE;
                end else begin
                    nextLatCnt = latCnt - LAT_W'(1);
                end
            end
            MEM_RELEASE: begin
                nextState = RUN;
            end
            default: begin
                nextState  = RUN;
                nextLatCnt = '0;
            end
        endcase
    end

    // Pipeline control decode: freeze > taken branch > load-use > jump > normal.
    // A taken branch beats load-use because the stalled instruction is on the
    // wrong path anyway.
    always_comb begin
        pc_write_o    = 1'b1;
        if_id_write_o = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_write_o = 1'b1;
        id_ex_flush_o = 1'b0;
        back_write_o  = 1'b1;
        if (freeze) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_write_o = 1'b0;
            back_write_o  = 1'b0;
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (loadUse) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
        end else if (jump_i) begin
            if_id_flush_o = 1'b1;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) uStallCnt (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .inc_i  (~pc_write_o),
        .clr_i  (cnt_clr_i),
        .cnt_o  (stall_cnt_o)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) uFlushCnt (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .inc_i  (if_id_flush_o),
        .clr_i  (cnt_clr_i),
        .cnt_o  (flush_cnt_o)
    );

endmodule
